// File: rtl/xbar_alloc_pkg.sv
// xbar_alloc_pkg: constants and types shared by the switch allocator files.
//   NPORTS     - router port count (fixed at 5)
//   LOCAL_PORT - ejection/injection port, never used as a deflection target
//   CTL_IDLE   - crossbar select code for an unassigned output
//   PORT_W     - width of a port index / select code
package xbar_alloc_pkg;
    localparam int NPORTS = 5;
    localparam int LOCAL_PORT = 4;
    localparam int PORT_W = 3;
    typedef logic [PORT_W-1:0] port_t;
    localparam port_t CTL_IDLE = 3'd7;
endpackage

// File: rtl/xbar_alloc_if.sv
// xbar_alloc_if: request/select bundle between the router pipeline and the allocator.
//   req_valid, req_port0..4       - routed flit requests (master -> slave)
//   ctl0..4, out_valid            - registered crossbar selects (slave -> master)
//   grant, deflect, stall         - registered per-input outcome (slave -> master)
interface xbar_alloc_if;
    import xbar_alloc_pkg::*;
    logic [NPORTS-1:0] req_valid;
    port_t req_port0, req_port1, req_port2, req_port3, req_port4;
    port_t ctl0, ctl1, ctl2, ctl3, ctl4;
    logic [NPORTS-1:0] out_valid, grant, deflect, stall;
    modport master (
        output req_valid, req_port0, req_port1, req_port2, req_port3, req_port4,
        input ctl0, ctl1, ctl2, ctl3, ctl4, out_valid, grant, deflect, stall
    );
    modport slave (
        input req_valid, req_port0, req_port1, req_port2, req_port3, req_port4,
        output ctl0, ctl1, ctl2, ctl3, ctl4, out_valid, grant, deflect, stall
    );
endinterface

// File: rtl/xbar_alloc_free_pick.sv
// xbar_alloc_free_pick: lowest-index free output finder.
//   free          - mask of outputs still unassigned
//   only_nonlocal - exclude LOCAL_PORT from the search
//   found, idx    - a free output exists / its index
module xbar_alloc_free_pick
    import xbar_alloc_pkg::*;
(
    input  logic [NPORTS-1:0] free,
    input  logic              only_nonlocal,
    output logic              found,
    output port_t             idx
);
    logic [NPORTS-1:0] eff;
    always_comb begin
        eff = only_nonlocal ? free & ~(NPORTS'(1) << LOCAL_PORT) : free;
        found = |eff;
        idx = eff[0] ? 3'd0 : eff[1] ? 3'd1 : eff[2] ? 3'd2 : eff[3] ? 3'd3 : 3'd4;
    end
endmodule

// File: rtl/xbar_alloc.sv
// xbar_alloc: 5x5 crossbar switch allocator with rotating priority and deflection.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - slave side of xbar_alloc_if: requests in, registered selects and
//              grant/deflect/stall status out, one cycle after the request
module xbar_alloc
    import xbar_alloc_pkg::*;
(
    input logic        clk,
    input logic        rst,
    xbar_alloc_if.slave bus
);
    port_t prio;
    port_t rp [NPORTS];
    port_t svc [NPORTS];
    logic [NPORTS-1:0] taken, won, dfl, ov_n, s_n;
    logic [NPORTS-1:0] ok_v;
    port_t sidx [NPORTS];
    port_t ctl_n [NPORTS];
    port_t ctl_q [NPORTS];
    logic [NPORTS-1:0] ov_q, g_q, d_q, s_q;

    assign rp[0] = bus.req_port0;
    assign rp[1] = bus.req_port1;
    assign rp[2] = bus.req_port2;
    assign rp[3] = bus.req_port3;
    assign rp[4] = bus.req_port4;

    // svc[k] is the input served k-th this cycle: (prio + k) mod 5
    genvar k;
    for (k = 0; k < NPORTS; k++) begin : g_svc
        logic [3:0] sum;
        assign sum = {1'b0, prio} + 4'(k);
        assign svc[k] = sum >= 4'(NPORTS) ? port_t'(sum - 4'(NPORTS)) : port_t'(sum);
    end

    // Productive phase: each valid input claims its desired output if still free
    always_comb begin
        taken = '0;
        won = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (bus.req_valid[svc[i]] && rp[svc[i]] < port_t'(NPORTS) && !taken[rp[svc[i]]]) begin
                taken[rp[svc[i]]] = 1'b1;
                won[svc[i]] = 1'b1;
            end
        end
    end

    // Deflection phase: a chain of pickers in service order, each stage seeing the
    // free mask left by the stages before it. Separate per-stage nets keep the chain
    // free of self-referencing vectors.
    for (k = 0; k < NPORTS; k++) begin : g_dfl
        logic [NPORTS-1:0] m_in, m_out;
        logic need, fnd;
        port_t idx;
        if (k == 0) begin : g_first
            assign m_in = ~taken;
        end else begin : g_next
            assign m_in = g_dfl[k-1].m_out;
        end
        assign need = bus.req_valid[svc[k]] & ~won[svc[k]];
        xbar_alloc_free_pick u_pick (
            .free(m_in),
            .only_nonlocal(1'b1),
            .found(fnd),
            .idx(idx)
        );
        assign m_out = need & fnd ? m_in & ~(NPORTS'(1) << idx) : m_in;
        assign ok_v[k] = need & fnd;
        assign sidx[k] = idx;
    end

    always_comb begin
        dfl = '0;
        ov_n = '0;
        for (int j = 0; j < NPORTS; j++) ctl_n[j] = CTL_IDLE;
        for (int i = 0; i < NPORTS; i++) begin
            if (won[svc[i]]) begin
                ctl_n[rp[svc[i]]] = svc[i];
                ov_n[rp[svc[i]]] = 1'b1;
            end
            if (ok_v[i]) begin
                ctl_n[sidx[i]] = svc[i];
                ov_n[sidx[i]] = 1'b1;
                dfl[svc[i]] = 1'b1;
            end
        end
        s_n = bus.req_valid & ~won & ~dfl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= '0;
            ctl_q <= '{default: CTL_IDLE};
            ov_q <= '0;
            g_q <= '0;
            d_q <= '0;
            s_q <= '0;
        end else begin
            if (|bus.req_valid) prio <= prio == port_t'(NPORTS - 1) ? '0 : prio + 1'b1;
            ctl_q <= ctl_n;
            ov_q <= ov_n;
            g_q <= won;
            d_q <= dfl;
            s_q <= s_n;
        end
    end

    assign bus.ctl0 = ctl_q[0];
    assign bus.ctl1 = ctl_q[1];
    assign bus.ctl2 = ctl_q[2];
    assign bus.ctl3 = ctl_q[3];
    assign bus.ctl4 = ctl_q[4];
    assign bus.out_valid = ov_q;
    assign bus.grant = g_q;
    assign bus.deflect = d_q;
    assign bus.stall = s_q;
endmodule

// File: tb/tb_xbar_alloc.sv
// tb_xbar_alloc: randomized and directed bench for xbar_alloc against a behavioural model.
module tb_xbar_alloc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xbar_alloc_if bus();
    xbar_alloc dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int mprio = 0;
    logic [2:0] rp [5];
    logic [2:0] e_ctl [5];
    logic [4:0] e_ov, e_g, e_d, e_s;
    logic [2:0] act_ctl [5];

    assign act_ctl[0] = bus.ctl0;
    assign act_ctl[1] = bus.ctl1;
    assign act_ctl[2] = bus.ctl2;
    assign act_ctl[3] = bus.ctl3;
    assign act_ctl[4] = bus.ctl4;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic drive(input logic [4:0] v);
        bus.req_valid = v;
        bus.req_port0 = rp[0];
        bus.req_port1 = rp[1];
        bus.req_port2 = rp[2];
        bus.req_port3 = rp[3];
        bus.req_port4 = rp[4];
    endtask

    // owner[j]: input holding output j (-1 none); got[i]: output given to input i (-1 none)
    task automatic model(input logic [4:0] v);
        int owner [5];
        int got [5];
        int i;
        for (int j = 0; j < 5; j++) begin
            owner[j] = -1;
            got[j] = -1;
        end
        for (int k = 0; k < 5; k++) begin
            i = (mprio + k) % 5;
            if (v[i] && rp[i] < 5)
                if (owner[rp[i]] < 0) begin
                    owner[rp[i]] = i;
                    got[i] = int'(rp[i]);
                end
        end
        for (int k = 0; k < 5; k++) begin
            i = (mprio + k) % 5;
            if (v[i] && got[i] < 0)
                for (int j = 0; j < 4; j++)
                    if (owner[j] < 0 && got[i] < 0) begin
                        owner[j] = i;
                        got[i] = j;
                    end
        end
        for (int j = 0; j < 5; j++) begin
            e_ctl[j] = owner[j] < 0 ? 3'd7 : 3'(owner[j]);
            e_ov[j] = owner[j] >= 0;
            e_g[j] = v[j] && got[j] == int'(rp[j]);
            e_d[j] = v[j] && got[j] >= 0 && got[j] != int'(rp[j]);
            e_s[j] = v[j] && got[j] < 0;
        end
    endtask

    task automatic step(input logic [4:0] v);
        int bad;
        int cnt;
        @(negedge clk);
        drive(v);
        model(v);
        @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++) chk($sformatf("ctl%0d", j), 8'(act_ctl[j]), 8'(e_ctl[j]));
        chk("out_valid", 8'(bus.out_valid), 8'(e_ov));
        chk("grant", 8'(bus.grant), 8'(e_g));
        chk("deflect", 8'(bus.deflect), 8'(e_d));
        chk("stall", 8'(bus.stall), 8'(e_s));
        bad = 0;
        for (int j = 0; j < 5; j++)
            for (int m = j + 1; m < 5; m++)
                if (act_ctl[j] != 3'd7 && act_ctl[j] == act_ctl[m]) bad++;
        chk("no_dup_ctl", 8'(bad), 8'd0);
        for (int i = 0; i < 5; i++) begin
            cnt = int'(bus.grant[i]) + int'(bus.deflect[i]) + int'(bus.stall[i]);
            chk($sformatf("one_outcome%0d", i), 8'(cnt), 8'(v[i]));
        end
        if (v != 0) mprio = (mprio + 1) % 5;
    endtask

    task automatic chk_reset(input string n);
        for (int j = 0; j < 5; j++) chk({n, "_ctl"}, 8'(act_ctl[j]), 8'd7);
        chk({n, "_ov"}, 8'(bus.out_valid), 8'd0);
        chk({n, "_grant"}, 8'(bus.grant), 8'd0);
        chk({n, "_deflect"}, 8'(bus.deflect), 8'd0);
        chk({n, "_stall"}, 8'(bus.stall), 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) rp[i] = 3'd0;
        drive(5'b0);
        #12;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 5; i++) rp[i] = 3'($urandom_range(0, 7));
            step(5'($urandom));
        end
        for (int i = 0; i < 5; i++) rp[i] = 3'($urandom_range(0, 4));
        step(5'b11111);
        chk("pre_rst_busy", 8'(bus.out_valid != 0), 8'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        mprio = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(5'b0);
        rst = 1'b0;

        rp[0] = 3'd2;
        rp[1] = 3'd2;
        step(5'b00011);
        chk("c0_ctl2", 8'(act_ctl[2]), 8'd0);
        chk("c0_ctl0", 8'(act_ctl[0]), 8'd1);
        chk("c0_grant", 8'(bus.grant), 8'b00001);
        chk("c0_deflect", 8'(bus.deflect), 8'b00010);
        step(5'b00000);
        chk("idle_ov", 8'(bus.out_valid), 8'd0);
        step(5'b00011);
        chk("c1_ctl2", 8'(act_ctl[2]), 8'd1);
        chk("c1_ctl0", 8'(act_ctl[0]), 8'd0);
        chk("c1_grant", 8'(bus.grant), 8'b00010);
        chk("c1_deflect", 8'(bus.deflect), 8'b00001);

        rp[0] = 3'd2;
        rp[1] = 3'd3;
        step(5'b00011);
        chk("nc_ctl2", 8'(act_ctl[2]), 8'd0);
        chk("nc_ctl3", 8'(act_ctl[3]), 8'd1);
        chk("nc_ctl0", 8'(act_ctl[0]), 8'd7);
        chk("nc_grant", 8'(bus.grant), 8'b00011);
        chk("nc_ov", 8'(bus.out_valid), 8'b01100);

        rp[2] = 3'd1;
        step(5'b00100);
        step(5'b00100);
        for (int i = 0; i < 5; i++) rp[i] = 3'd0;
        step(5'b11111);
        chk("full_ctl0", 8'(act_ctl[0]), 8'd0);
        chk("full_ctl1", 8'(act_ctl[1]), 8'd1);
        chk("full_ctl2", 8'(act_ctl[2]), 8'd2);
        chk("full_ctl3", 8'(act_ctl[3]), 8'd3);
        chk("full_ctl4", 8'(act_ctl[4]), 8'd7);
        chk("full_grant", 8'(bus.grant), 8'b00001);
        chk("full_deflect", 8'(bus.deflect), 8'b01110);
        chk("full_stall", 8'(bus.stall), 8'b10000);

        rp[4] = 3'd7;
        step(5'b10000);
        chk("any_ctl0", 8'(act_ctl[0]), 8'd4);
        chk("any_deflect", 8'(bus.deflect), 8'b10000);
        chk("any_grant", 8'(bus.grant), 8'd0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 5; i++)
                rp[i] = n % 3 == 0 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
            step(n % 7 == 0 ? 5'b0 : 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
